// File: rtl/razor_pkg.sv
// Shared definitions for the razor recovery controller: FSM encodings and a
// counter-width helper.
package razor_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStall  = 2'd1,
    StReplay = 2'd2
  } razor_state_e;

  // Bits needed to hold values 0..value-1, never less than one.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(value)) w++;
    return w;
  endfunction

endpackage

// File: rtl/razor_rate_monitor.sv
// Sliding-window event-rate monitor; raises a sticky throttle request once
// THRESH recovery events land inside one WINDOW-cycle window.
module razor_rate_monitor
  import razor_pkg::*;
#(
  parameter int unsigned WINDOW = 256,
  parameter int unsigned THRESH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic event_i,
  input  logic clr_i,
  output logic throttle_req_o
);

  localparam int unsigned WinW = clog2(WINDOW);
  localparam int unsigned EvW  = clog2(THRESH + 1);

  logic [WinW-1:0] win_cnt_q;
  logic [EvW-1:0]  win_events_q;
  logic            wrap;

  assign wrap = (win_cnt_q == WinW'(WINDOW - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt_q      <= '0;
      win_events_q   <= '0;
      throttle_req_o <= 1'b0;
    end else if (clr_i) begin
      win_cnt_q      <= '0;
      win_events_q   <= EvW'(event_i);
      throttle_req_o <= 1'b0;
    end else begin
      win_cnt_q <= wrap ? '0 : win_cnt_q + 1'b1;
      // An event on the wrap edge belongs to the new window.
      if (wrap) begin
        win_events_q <= EvW'(event_i);
      end else if (event_i && (win_events_q < EvW'(THRESH))) begin
        win_events_q <= win_events_q + 1'b1;
      end
      if (win_events_q >= EvW'(THRESH)) begin
        throttle_req_o <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/razor_recovery_ctrl.sv
// Razor error aggregation and stall-then-replay recovery sequencer for one
// pipeline stage, with lifetime error count and rate-based throttle request.
module razor_recovery_ctrl
  import razor_pkg::*;
#(
  parameter int unsigned NUM_BITS     = 32,
  parameter int unsigned STALL_CYCLES = 2,
  parameter int unsigned WINDOW       = 256,
  parameter int unsigned THRESH       = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BITS-1:0] err_vec,
  input  logic [NUM_BITS-1:0] err_mask,
  input  logic                clr_i,
  output logic                stall_o,
  output logic                replay_o,
  output logic                busy_o,
  output logic [NUM_BITS-1:0] err_bits_o,
  output logic [CNT_W-1:0]    err_count_o,
  output logic                throttle_req_o
);

  localparam int unsigned StallW = clog2(STALL_CYCLES);

  razor_state_e        state_q, state_d;
  logic [StallW-1:0]   stall_cnt_q, stall_cnt_d;
  logic [NUM_BITS-1:0] err_masked;
  logic                err_any;
  logic                event_start;
  logic [NUM_BITS-1:0] err_bits_d;
  logic [CNT_W-1:0]    err_count_d;

  assign err_masked = err_vec & err_mask;
  assign err_any    = |err_masked;

  // REPLAY lasts exactly one cycle, so an error seen there (the pending
  // case) is resolved on the same edge that leaves REPLAY.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    event_start = 1'b0;
    case (state_q)
      StIdle: begin
        if (err_any) begin
          state_d     = StStall;
          stall_cnt_d = StallW'(STALL_CYCLES - 1);
          event_start = 1'b1;
        end
      end
      StStall: begin
        if (stall_cnt_q == '0) begin
          state_d = StReplay;
        end else begin
          stall_cnt_d = stall_cnt_q - 1'b1;
        end
      end
      StReplay: begin
        if (err_any) begin
          state_d     = StStall;
          stall_cnt_d = StallW'(STALL_CYCLES - 1);
          event_start = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    err_bits_d = err_bits_o;
    if (clr_i) begin
      err_bits_d = event_start ? err_masked : '0;
    end else if (event_start) begin
      err_bits_d = err_masked;
    end else if ((state_q == StStall) && err_any) begin
      err_bits_d = err_bits_o | err_masked;
    end
  end

  always_comb begin
    err_count_d = err_count_o;
    if (clr_i) begin
      err_count_d = CNT_W'(err_any);
    end else if (err_any && (err_count_o != '1)) begin
      err_count_d = err_count_o + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      stall_cnt_q <= '0;
      stall_o     <= 1'b0;
      replay_o    <= 1'b0;
      busy_o      <= 1'b0;
      err_bits_o  <= '0;
      err_count_o <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      stall_o     <= (state_d == StStall);
      replay_o    <= (state_d == StReplay);
      busy_o      <= (state_d != StIdle);
      err_bits_o  <= err_bits_d;
      err_count_o <= err_count_d;
    end
  end

  razor_rate_monitor #(
    .WINDOW (WINDOW),
    .THRESH (THRESH)
  ) u_rate_monitor (
    .clk            (clk),
    .reset          (reset),
    .event_i        (event_start),
    .clr_i          (clr_i),
    .throttle_req_o (throttle_req_o)
  );

endmodule
